// File: rtl/fifo_arb_pkg.sv
// Shared constants for the sync_fifo write-port arbiter and its benches:
// FSM encoding and default sizing.
package fifo_arb_pkg;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_GRANT = 1'b1;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  typedef enum logic {
    IDLE  = STATE_IDLE,
    GRANT = STATE_GRANT
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: rotate the request vector so the search
// starts just after last_grant, priority-encode, then rotate the index back.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    pick_id,
  output logic               pick_vld
);

  int                start_idx;
  logic [NUM_REQ-1:0] rot;
  logic [ID_W-1:0]    src_idx [NUM_REQ];
  logic [ID_W-1:0]    enc;

  assign start_idx = (int'(last_grant) + 1) % NUM_REQ;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign src_idx[gi] = ID_W'((start_idx + gi) % NUM_REQ);
    assign rot[gi]     = req_valid[src_idx[gi]];
  end

  // Lowest set bit of the rotated vector is the nearest requester after last_grant.
  always_comb begin
    enc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = ID_W'(i);
    end
  end

  assign pick_vld = |rot;
  assign pick_id  = ID_W'((int'(enc) + start_idx) % NUM_REQ);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the sync_fifo write port among NUM_REQ producers,
// with burst locking per grant and a hard guarantee of never writing while full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [WIDTH-1:0]         fifo_wdata,
  output logic [ID_W-1:0]          grant_id,
  output logic                     busy,
  output logic [15:0]              wr_count
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_reg, state_next;
  logic [ID_W-1:0]   grant_id_reg, grant_id_next;
  logic [ID_W-1:0]   last_grant_reg, last_grant_next;
  logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next, beat_inc;
  logic [15:0]       wr_count_reg, wr_count_next;
  logic [ID_W-1:0]   pick_id;
  logic              pick_vld;
  logic              granted, sel_valid, sel_last, xfer;
  logic [WIDTH-1:0]  sel_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant_reg),
    .pick_id    (pick_id),
    .pick_vld   (pick_vld)
  );

  // Outputs are gated by res so nothing leaks through during the reset cycle.
  assign granted   = (state_reg == GRANT) && !res;
  assign sel_valid = req_valid[grant_id_reg];
  assign sel_last  = req_last[grant_id_reg];
  assign sel_data  = req_data[grant_id_reg*WIDTH +: WIDTH];
  assign xfer      = granted && sel_valid && !fifo_full;
  assign beat_inc  = beat_cnt_reg + 1'b1;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = granted && !fifo_full && (grant_id_reg == ID_W'(gi));
  end

  assign fifo_wr_en = xfer;
  assign fifo_wdata = xfer ? sel_data : '0;
  assign grant_id   = grant_id_reg;
  assign busy       = (state_reg == GRANT);
  assign wr_count   = wr_count_reg;

  always_comb begin
    state_next      = state_reg;
    grant_id_next   = grant_id_reg;
    last_grant_next = last_grant_reg;
    beat_cnt_next   = beat_cnt_reg;
    wr_count_next   = wr_count_reg + 16'(xfer);
    case (state_reg)
      IDLE: begin
        if (pick_vld) begin
          state_next    = GRANT;
          grant_id_next = pick_id;
          beat_cnt_next = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          beat_cnt_next = beat_inc;
          if (sel_last || (beat_inc == BEAT_W'(MAX_BURST))) begin
            state_next      = IDLE;
            last_grant_next = grant_id_reg;
          end
        end else if (!sel_valid && !fifo_full) begin
          // Producer dropped valid; a full FIFO instead holds the grant indefinitely.
          state_next      = IDLE;
          last_grant_next = grant_id_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg      <= IDLE;
      grant_id_reg   <= '0;
      last_grant_reg <= ID_W'(NUM_REQ - 1);
      beat_cnt_reg   <= '0;
      wr_count_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      grant_id_reg   <= grant_id_next;
      last_grant_reg <= last_grant_next;
      beat_cnt_reg   <= beat_cnt_next;
      wr_count_reg   <= wr_count_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed per-cycle vector table plus hand-written sequences (burst cap,
// backpressure with a 16-deep FIFO model, randomized concurrent traffic).
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        res;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wdata;
  logic [1:0]  grant_id;
  logic        busy;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .WIDTH     (8),
    .NUM_REQ   (4),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .res        (res),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .wr_count   (wr_count)
  );

  typedef struct {
    logic        res;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic        exp_wr;
    logic [7:0]  exp_wdata;
    logic [1:0]  exp_gid;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NVEC = 27;
  vec_t tbl [NVEC];

  logic [7:0]  fq [$];
  logic [9:0]  wlog [$];
  logic [5:0]  seq [4];
  logic [5:0]  exp_seq [4];
  int          gap [4];
  int          p1_sent, p3_sent, p0_sent;
  logic [7:0]  popped;

  function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic f, logic [31:0] d,
                              logic [3:0] er, logic ew, logic [7:0] ed, logic [1:0] eg,
                              logic eb, logic [15:0] ec);
    vec_t t;
    t.res = r; t.valid = v; t.last = l; t.full = f; t.data = d;
    t.exp_ready = er; t.exp_wr = ew; t.exp_wdata = ed; t.exp_gid = eg;
    t.exp_busy = eb; t.exp_cnt = ec;
    return t;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    res = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    res = 1'b0;
  endtask

  initial begin
    // res, valid, last, full, data | ready, wr, wdata, gid, busy, wr_count
    tbl[0]  = mk(1, 4'hF, 4'h0, 0, 32'h0,         4'h0, 0, 8'h00, 2'd0, 0, 16'd0);
    tbl[1]  = mk(0, 4'h4, 4'h0, 0, 32'h00A1_0000, 4'h0, 0, 8'h00, 2'd0, 0, 16'd0);
    tbl[2]  = mk(0, 4'h4, 4'h0, 0, 32'h00A1_0000, 4'h4, 1, 8'hA1, 2'd2, 1, 16'd0);
    tbl[3]  = mk(0, 4'h4, 4'h0, 0, 32'h00A2_0000, 4'h4, 1, 8'hA2, 2'd2, 1, 16'd1);
    tbl[4]  = mk(0, 4'h4, 4'h4, 0, 32'h00A3_0000, 4'h4, 1, 8'hA3, 2'd2, 1, 16'd2);
    tbl[5]  = mk(0, 4'h0, 4'h0, 0, 32'h0,         4'h0, 0, 8'h00, 2'd2, 0, 16'd3);
    tbl[6]  = mk(0, 4'hF, 4'hF, 0, 32'h3322_1100, 4'h0, 0, 8'h00, 2'd2, 0, 16'd3);
    tbl[7]  = mk(0, 4'hF, 4'hF, 0, 32'h3322_1100, 4'h8, 1, 8'h33, 2'd3, 1, 16'd3);
    tbl[8]  = mk(0, 4'hF, 4'hF, 0, 32'h3322_1100, 4'h0, 0, 8'h00, 2'd3, 0, 16'd4);
    tbl[9]  = mk(0, 4'hF, 4'hF, 0, 32'h3322_1100, 4'h1, 1, 8'h00, 2'd0, 1, 16'd4);
    tbl[10] = mk(0, 4'hF, 4'hF, 0, 32'h3322_1100, 4'h0, 0, 8'h00, 2'd0, 0, 16'd5);
    tbl[11] = mk(0, 4'hF, 4'hF, 0, 32'h3322_1100, 4'h2, 1, 8'h11, 2'd1, 1, 16'd5);
    tbl[12] = mk(0, 4'hF, 4'hF, 0, 32'h3322_1100, 4'h0, 0, 8'h00, 2'd1, 0, 16'd6);
    tbl[13] = mk(0, 4'hF, 4'hF, 0, 32'h3322_1100, 4'h4, 1, 8'h22, 2'd2, 1, 16'd6);
    tbl[14] = mk(0, 4'h1, 4'h0, 0, 32'h0000_0055, 4'h0, 0, 8'h00, 2'd2, 0, 16'd7);
    tbl[15] = mk(0, 4'h1, 4'h0, 1, 32'h0000_0055, 4'h0, 0, 8'h00, 2'd0, 1, 16'd7);
    tbl[16] = mk(0, 4'h0, 4'h0, 1, 32'h0000_0055, 4'h0, 0, 8'h00, 2'd0, 1, 16'd7);
    tbl[17] = mk(0, 4'h1, 4'h0, 0, 32'h0000_0055, 4'h1, 1, 8'h55, 2'd0, 1, 16'd7);
    tbl[18] = mk(0, 4'h0, 4'h0, 0, 32'h0000_0055, 4'h1, 0, 8'h00, 2'd0, 1, 16'd8);
    tbl[19] = mk(0, 4'h0, 4'h0, 0, 32'h0,         4'h0, 0, 8'h00, 2'd0, 0, 16'd8);
    tbl[20] = mk(0, 4'h4, 4'h0, 0, 32'h00C1_0000, 4'h0, 0, 8'h00, 2'd0, 0, 16'd8);
    tbl[21] = mk(0, 4'h4, 4'h0, 0, 32'h00C1_0000, 4'h4, 1, 8'hC1, 2'd2, 1, 16'd8);
    tbl[22] = mk(0, 4'h4, 4'h0, 0, 32'h00C2_0000, 4'h4, 1, 8'hC2, 2'd2, 1, 16'd9);
    tbl[23] = mk(1, 4'h5, 4'h0, 0, 32'h00C3_00E0, 4'h0, 0, 8'h00, 2'd2, 1, 16'd10);
    tbl[24] = mk(0, 4'h5, 4'h1, 0, 32'h00C3_00E0, 4'h0, 0, 8'h00, 2'd0, 0, 16'd0);
    tbl[25] = mk(0, 4'h5, 4'h1, 0, 32'h00C3_00E0, 4'h1, 1, 8'hE0, 2'd0, 1, 16'd0);
    tbl[26] = mk(0, 4'h4, 4'h0, 0, 32'h00C3_00E0, 4'h0, 0, 8'h00, 2'd0, 0, 16'd1);

    res = 1'b1; req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
    @(posedge clk);
    #1;

    // Per-cycle table: drive just after the edge, check just before the next.
    for (int k = 0; k < NVEC; k++) begin
      res = tbl[k].res; req_valid = tbl[k].valid; req_last = tbl[k].last;
      fifo_full = tbl[k].full; req_data = tbl[k].data;
      #3;
      $display("vec %0d: wr_en=%0b wdata=%h gid=%0d busy=%0b wr_count=%0d",
               k, fifo_wr_en, fifo_wdata, grant_id, busy, wr_count);
      check($sformatf("v%0d_ready", k), req_ready, tbl[k].exp_ready);
      check($sformatf("v%0d_wr_en", k), fifo_wr_en, tbl[k].exp_wr);
      check($sformatf("v%0d_wdata", k), fifo_wdata, tbl[k].exp_wdata);
      check($sformatf("v%0d_gid", k), grant_id, tbl[k].exp_gid);
      check($sformatf("v%0d_busy", k), busy, tbl[k].exp_busy);
      check($sformatf("v%0d_wr_count", k), wr_count, tbl[k].exp_cnt);
      @(posedge clk);
      #1;
    end

    // Burst cap: producer 1 streams 10 beats, producer 3 sends one packet.
    do_reset();
    p1_sent = 0; p3_sent = 0; wlog.delete();
    for (int c = 0; c < 30; c++) begin
      req_valid = {(p3_sent == 0), 1'b0, (p1_sent < 10), 1'b0};
      req_last  = 4'b1000;
      req_data  = {8'h3F, 8'h00, 8'(8'h10 + p1_sent), 8'h00};
      #3;
      if (fifo_wr_en) begin
        wlog.push_back({grant_id, fifo_wdata});
        $display("burst write: id=%0d data=%h", grant_id, fifo_wdata);
      end
      if (req_valid[1] && req_ready[1]) p1_sent++;
      if (req_valid[3] && req_ready[3]) p3_sent++;
      @(posedge clk);
      #1;
    end
    begin
      logic [9:0] exp_log [11];
      exp_log = '{{2'd1, 8'h10}, {2'd1, 8'h11}, {2'd1, 8'h12}, {2'd1, 8'h13}, {2'd3, 8'h3F},
                  {2'd1, 8'h14}, {2'd1, 8'h15}, {2'd1, 8'h16}, {2'd1, 8'h17},
                  {2'd1, 8'h18}, {2'd1, 8'h19}};
      check("burst_len", wlog.size(), 11);
      for (int k = 0; k < 11 && k < wlog.size(); k++)
        check($sformatf("burst_%0d", k), wlog[k], exp_log[k]);
    end

    // Backpressure: fill a 16-deep FIFO, hold, then free one slot.
    do_reset();
    fq.delete(); p0_sent = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 35) begin
        popped = fq.pop_front();
        check("bp_pop_first", popped, 8'h00);
      end
      fifo_full = (fq.size() == 16);
      req_valid = 4'b0001; req_last = 4'b0000;
      req_data  = {24'h0, 8'(p0_sent)};
      #3;
      if (fifo_full) begin
        check($sformatf("bp_ready_c%0d", c), req_ready, 4'h0);
        check($sformatf("bp_wr_en_c%0d", c), fifo_wr_en, 1'b0);
      end
      if (c == 35) begin
        check("bp_resume_wr_en", fifo_wr_en, 1'b1);
        check("bp_resume_wdata", fifo_wdata, 8'h10);
      end
      if (fifo_wr_en) begin
        fq.push_back(fifo_wdata);
        $display("bp write: data=%h depth=%0d", fifo_wdata, fq.size());
      end
      if (req_valid[0] && req_ready[0]) p0_sent++;
      @(posedge clk);
      #1;
    end
    check("bp_depth", fq.size(), 16);
    for (int k = 1; k <= 16 && fq.size() > 0; k++) begin
      popped = fq.pop_front();
      check($sformatf("bp_read_%0d", k), popped, k[7:0]);
    end

    // Concurrent random traffic with random reads; per-producer order must hold.
    do_reset();
    fq.delete();
    for (int i = 0; i < 4; i++) begin
      seq[i] = '0; exp_seq[i] = '0; gap[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      if (fq.size() > 0 && $urandom_range(0, 2) == 0) begin
        popped = fq.pop_front();
        check($sformatf("rnd_order_p%0d", popped[7:6]), popped[5:0], exp_seq[popped[7:6]]);
        exp_seq[popped[7:6]] = exp_seq[popped[7:6]] + 1'b1;
      end
      fifo_full = (fq.size() == 16);
      for (int i = 0; i < 4; i++) begin
        req_valid[i]        = (gap[i] == 0);
        req_last[i]         = ($urandom_range(0, 3) == 0);
        req_data[8*i +: 8]  = {2'(i), seq[i]};
      end
      #3;
      if (fifo_wr_en) begin
        check("rnd_no_overflow", fifo_full, 1'b0);
        fq.push_back(fifo_wdata);
        $display("rnd write: id=%0d data=%h depth=%0d", grant_id, fifo_wdata, fq.size());
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          seq[i] = seq[i] + 1'b1;
          if ($urandom_range(0, 2) == 0) gap[i] = $urandom_range(5, 10);
        end else if (gap[i] > 0) begin
          gap[i]--;
        end
      end
      @(posedge clk);
      #1;
    end
    while (fq.size() > 0) begin
      popped = fq.pop_front();
      check($sformatf("rnd_drain_p%0d", popped[7:6]), popped[5:0], exp_seq[popped[7:6]]);
      exp_seq[popped[7:6]] = exp_seq[popped[7:6]] + 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
